debounce_pulse: RTL and testbench



---
 rtl/debounce_pulse_if.sv | 21 ++
 rtl/debounce_pulse.sv | 105 ++++++++++
 tb/tb_debounce_pulse.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/debounce_pulse_if.sv
// Button-conditioning interface: raw input toward the debouncer, clean level and strobes back.
interface debounce_pulse_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/debounce_pulse.sv
// Two-flop synchronizer plus stability-counter FSM producing a debounced level and
// single-cycle press/release strobes.
//
// state    | meaning
// IDLE     | stable low
// ARM_HIGH | qualifying a high
// HIGH     | stable high
// ARM_LOW  | qualifying a low
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic             clk,
  input logic             reset,
  debounce_pulse_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM_HIGH, HIGH, ARM_LOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= bus.btn_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = ARM_HIGH;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ARM_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = ARM_LOW;
          cnt_d   = CW'(1);
        end
      end
      ARM_LOW: begin
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes fire only on completed qualification, never on an aborted ARM_* return.
  always_comb begin
    level_d   = (state_d == HIGH) || (state_d == ARM_LOW);
    press_d   = (state_q == ARM_HIGH) && (state_d == HIGH);
    release_d = (state_q == ARM_LOW) && (state_d == IDLE);
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse with DEBOUNCE_CYCLES=4 against a run-length reference model.
module tb_debounce_pulse;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  debounce_pulse_if bus ();
  debounce_pulse #(.DEBOUNCE_CYCLES(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: level flips once N consecutive synchronized samples disagree with it.
  logic m_s1, m_s2, m_level, m_press, m_rel;
  int   m_run;

  task automatic tick(input logic b, input logic r);
    logic sample;
    bus.btn_in = b;
    reset = r;
    @(posedge clk);
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_press = 0; m_rel = 0;
    end else begin
      sample = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      m_press = 0;
      m_rel = 0;
      if (sample != m_level) begin
        m_run++;
        if (m_run == N) begin
          m_level = ~m_level;
          m_run = 0;
          if (m_level) m_press = 1; else m_rel = 1;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic check_model(input string name);
    vectors++;
    if ({bus.btn_level, bus.press_pulse, bus.release_pulse} !== {m_level, m_press, m_rel}) begin
      miscompares++;
      $display("FAIL %s: got lvl/press/rel=%b%b%b expected %b%b%b at %0t", name,
               bus.btn_level, bus.press_pulse, bus.release_pulse, m_level, m_press, m_rel, $time);
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      vectors++;
      if ({bus.btn_level, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_hold: got %b expected 000", {bus.btn_level, bus.press_pulse, bus.release_pulse});
      end
    end
    for (int e = 1; e <= 7; e++) begin
      tick(1'b1, 1'b0);
      exp = (e <= 5) ? 3'b000 : (e == 6) ? 3'b110 : 3'b100;
      vectors++;
      if ({bus.btn_level, bus.press_pulse, bus.release_pulse} !== exp) begin
        miscompares++;
        $display("FAIL reset_release r+%0d: got %b expected %b", e,
                 {bus.btn_level, bus.press_pulse, bus.release_pulse}, exp);
      end
      check_model("reset_release_model");
    end
  endtask

  task automatic go_idle();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_clean_press();
    go_idle();
    for (int e = 0; e <= 8; e++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if (bus.press_pulse !== (e == 5) || bus.btn_level !== (e >= 5)) begin
        miscompares++;
        $display("FAIL clean_press k+%0d: got level=%b press=%b expected level=%b press=%b", e,
                 bus.btn_level, bus.press_pulse, (e >= 5), (e == 5));
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [7] = '{1, 1, 0, 1, 1, 1, 1};
    int presses = 0;
    go_idle();
    for (int e = 0; e < 12; e++) begin
      tick((e < 7) ? pat[e] : 1'b1, 1'b0);
      if (bus.press_pulse) presses++;
      vectors++;
      if (bus.press_pulse !== (e == 8)) begin
        miscompares++;
        $display("FAIL bounce_press edge %0d: got %b expected %b", e, bus.press_pulse, (e == 8));
      end
      check_model("bounce_model");
    end
    vectors++;
    if (presses != 1) begin
      miscompares++;
      $display("FAIL bounce_count: got %0d presses expected 1", presses);
    end
  endtask

  task automatic test_glitch();
    int rels = 0;
    for (int e = 0; e < 12; e++) begin
      tick((e < 3) ? 1'b0 : 1'b1, 1'b0);
      vectors++;
      if (bus.btn_level !== 1'b1 || bus.release_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_reject edge %0d: got level=%b rel=%b expected level=1 rel=0", e,
                 bus.btn_level, bus.release_pulse);
      end
    end
    for (int e = 0; e < 10; e++) begin
      tick(1'b0, 1'b0);
      if (bus.release_pulse) rels++;
      check_model("glitch_release_model");
    end
    vectors++;
    if (rels != 1 || bus.btn_level !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_release: got rels=%0d level=%b expected rels=1 level=0", rels, bus.btn_level);
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    for (int e = 0; e < 4; e++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if (bus.press_pulse !== (e == 6) || bus.btn_level !== (e >= 6)) begin
        miscompares++;
        $display("FAIL reset_mid r+%0d: got level=%b press=%b expected level=%b press=%b", e,
                 bus.btn_level, bus.press_pulse, (e >= 6), (e == 6));
      end
    end
    tick(1'b1, 1'b1);
    vectors++;
    if ({bus.btn_level, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_in_high: got %b expected 000", {bus.btn_level, bus.press_pulse, bus.release_pulse});
    end
  endtask

  task automatic test_random();
    logic b = 0;
    logic prev_level = 0, prev_press = 0, prev_rel = 0;
    int hold = 0, presses = 0, rises = 0;
    go_idle();
    prev_level = bus.btn_level;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        b = ~b;
        hold = $urandom_range(1, 8);
      end
      hold--;
      tick(b, ($urandom_range(0, 199) == 0));
      check_model("random_model");
      vectors++;
      if ((bus.press_pulse && (prev_press || bus.release_pulse)) || (bus.release_pulse && prev_rel)) begin
        miscompares++;
        $display("FAIL random_pulse_shape cycle %0d: press=%b rel=%b prev_press=%b prev_rel=%b", i,
                 bus.press_pulse, bus.release_pulse, prev_press, prev_rel);
      end
      if (bus.press_pulse) presses++;
      if (bus.btn_level && !prev_level) rises++;
      prev_level = bus.btn_level;
      prev_press = bus.press_pulse;
      prev_rel = bus.release_pulse;
    end
    vectors++;
    if (presses != rises || presses == 0) begin
      miscompares++;
      $display("FAIL random_press_count: got presses=%0d expected rises=%0d (nonzero)", presses, rises);
    end
  endtask

  initial begin
    bus.btn_in = 1'b0;
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_press = 0; m_rel = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
